mem_arbiter: RTL and testbench

Two-master to one-slave memory arbiter that sits directly downstream of the core. It takes the core's instruction-fetch (imem) and load/store (dmem) valid/ready ports and serialises them onto a single shared memory port. Arbitration is registered, with fixed dmem priority and a bounded-starvation counter that guarantees fetch progress.

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master (fetch/load-store) to one-slave memory arbiter.
// Registered grant, dmem priority, bounded dmem streak while fetch waits.
module mem_arbiter #(
    parameter int unsigned RISCV_ADDR_WIDTH = 32,
    parameter int unsigned RISCV_WORD_WIDTH = 32,
    parameter int unsigned MAX_D_STREAK     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        imem_valid_i,
    output logic                        imem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] imem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] imem_wdata_i,
    input  logic [3:0]                  imem_we_i,
    output logic [RISCV_WORD_WIDTH-1:0] imem_rdata_o,
    input  logic                        dmem_valid_i,
    output logic                        dmem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] dmem_wdata_i,
    input  logic [3:0]                  dmem_we_i,
    output logic [RISCV_WORD_WIDTH-1:0] dmem_rdata_o,
    output logic                        mem_valid_o,
    input  logic                        mem_ready_i,
    output logic [RISCV_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [RISCV_WORD_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]                  mem_we_o,
    input  logic [RISCV_WORD_WIDTH-1:0] mem_rdata_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam logic [3:0] LP_MAX = 4'(MAX_D_STREAK);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_d_streak;
    logic [3:0] w_streak_nxt;
    logic       w_arb;
    logic       w_pick_d;
    logic       w_pick_i;
    logic       w_gnt_i;
    logic       w_gnt_d;

    // Completing master's valid still counts, so a held valid chains with no bubble.
    assign w_arb    = (r_state == IDLE) || mem_ready_i;
    assign w_pick_d = dmem_valid_i && (!imem_valid_i || (r_d_streak < LP_MAX));
    assign w_pick_i = imem_valid_i && !w_pick_d;

    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_d_streak;
        if (w_arb) begin
            unique case (1'b1)
                w_pick_d: begin
                    w_state_nxt = GNT_D;
                    if (!imem_valid_i)
                        w_streak_nxt = 4'd0;
                    else if (r_d_streak >= LP_MAX)
                        w_streak_nxt = LP_MAX;
                    else
                        w_streak_nxt = r_d_streak + 4'd1;
                end
                w_pick_i: begin
                    w_state_nxt  = GNT_I;
                    w_streak_nxt = 4'd0;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_d_streak <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_d_streak <= w_streak_nxt;
        end
    end

    assign w_gnt_i = (r_state == GNT_I);
    assign w_gnt_d = (r_state == GNT_D);

    assign mem_valid_o = (r_state != IDLE);

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 4'd0;
        if (w_gnt_i) begin
            mem_addr_o  = imem_addr_i;
            mem_wdata_o = imem_wdata_i;
            mem_we_o    = imem_we_i;
        end else if (w_gnt_d) begin
            mem_addr_o  = dmem_addr_i;
            mem_wdata_o = dmem_wdata_i;
            mem_we_o    = dmem_we_i;
        end
    end

    assign imem_ready_o = w_gnt_i && mem_ready_i;
    assign dmem_ready_o = w_gnt_d && mem_ready_i;
    assign imem_rdata_o = w_gnt_i ? mem_rdata_i : '0;
    assign dmem_rdata_o = w_gnt_d ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: master/slave models and a completion
// scoreboard with per-master expectation queues and a grant-order queue.
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  we;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_valid_i;
    logic        imem_ready_o;
    logic [31:0] imem_addr_i;
    logic [31:0] imem_wdata_i;
    logic [3:0]  imem_we_i;
    logic [31:0] imem_rdata_o;
    logic        dmem_valid_i;
    logic        dmem_ready_o;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic [3:0]  dmem_we_i;
    logic [31:0] dmem_rdata_o;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_rdata_i;

    txn_t iq[$];
    txn_t dq[$];
    txn_t xi[$];
    txn_t xd[$];
    byte  ord[$];

    int          checks;
    int          failures;
    int          lat;
    int          scnt;
    int          i_real;
    bit          i_fin;
    bit          d_fin;
    logic        use_ovr;
    logic [31:0] ovr;

    always #5 clk = ~clk;

    mem_arbiter #(
        .RISCV_ADDR_WIDTH(32),
        .RISCV_WORD_WIDTH(32),
        .MAX_D_STREAK(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_valid_i(imem_valid_i),
        .imem_ready_o(imem_ready_o),
        .imem_addr_i(imem_addr_i),
        .imem_wdata_i(imem_wdata_i),
        .imem_we_i(imem_we_i),
        .imem_rdata_o(imem_rdata_o),
        .dmem_valid_i(dmem_valid_i),
        .dmem_ready_o(dmem_ready_o),
        .dmem_addr_i(dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i),
        .dmem_we_i(dmem_we_i),
        .dmem_rdata_o(dmem_rdata_o),
        .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o),
        .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata_i = use_ovr ? ovr : rd_fn(mem_addr_o);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_i(input logic [31:0] a);
        txn_t t;
        t.addr  = a;
        t.wdata = '0;
        t.we    = 4'd0;
        t.rdata = use_ovr ? ovr : rd_fn(a);
        iq.push_back(t);
        xi.push_back(t);
    endtask

    task automatic push_d(input logic [31:0] a, input logic [3:0] we,
                          input logic [31:0] wd);
        txn_t t;
        t.addr  = a;
        t.wdata = wd;
        t.we    = we;
        t.rdata = use_ovr ? ovr : rd_fn(a);
        dq.push_back(t);
        xd.push_back(t);
    endtask

    task automatic exp_order(input string s);
        for (int k = 0; k < s.len(); k++)
            ord.push_back(s[k]);
    endtask

    task automatic chk_order(input byte b);
        if (ord.size() == 0)
            chk("order_unexpected", 64'(b), 64'd0);
        else
            chk("grant_order", 64'(ord.pop_front()), 64'(b));
    endtask

    // One clock: slave and masters update after the edge, monitor at negedge.
    task automatic tick();
        txn_t x;
        @(posedge clk);
        #1;
        if (mem_valid_o) begin
            if (mem_ready_i)
                scnt = 0;
            mem_ready_i = (scnt == lat);
            scnt++;
        end else begin
            mem_ready_i = 1'b0;
            scnt        = 0;
        end
        if (i_fin) begin
            void'(iq.pop_front());
            i_fin = 1'b0;
        end
        if (d_fin) begin
            void'(dq.pop_front());
            d_fin = 1'b0;
        end
        if (iq.size() > 0) begin
            imem_valid_i = 1'b1;
            imem_addr_i  = iq[0].addr;
            imem_wdata_i = iq[0].wdata;
            imem_we_i    = iq[0].we;
        end else begin
            imem_valid_i = 1'b0;
            imem_addr_i  = '0;
            imem_wdata_i = '0;
            imem_we_i    = 4'd0;
        end
        if (dq.size() > 0) begin
            dmem_valid_i = 1'b1;
            dmem_addr_i  = dq[0].addr;
            dmem_wdata_i = dq[0].wdata;
            dmem_we_i    = dq[0].we;
        end else begin
            dmem_valid_i = 1'b0;
            dmem_addr_i  = '0;
            dmem_wdata_i = '0;
            dmem_we_i    = 4'd0;
        end
        @(negedge clk);
        chk("ready_exclusive", 64'(imem_ready_o & dmem_ready_o), 64'd0);
        if (!mem_valid_o)
            chk("idle_outputs_zero",
                64'(|{mem_addr_o, mem_wdata_o, mem_we_o, imem_rdata_o,
                      dmem_rdata_o, imem_ready_o, dmem_ready_o}), 64'd0);
        if (imem_valid_i && imem_ready_o) begin
            i_fin = 1'b1;
            i_real++;
            if (xi.size() == 0) begin
                chk("imem_unexpected", 64'd1, 64'd0);
            end else begin
                x = xi.pop_front();
                chk("imem_addr", 64'(mem_addr_o), 64'(x.addr));
                chk("imem_rdata", 64'(imem_rdata_o), 64'(x.rdata));
                chk("streak_on_i", 64'(dut.r_d_streak), 64'd0);
            end
            chk_order("I");
        end
        if (dmem_valid_i && dmem_ready_o) begin
            d_fin = 1'b1;
            if (xd.size() == 0) begin
                chk("dmem_unexpected", 64'd1, 64'd0);
            end else begin
                x = xd.pop_front();
                chk("dmem_addr", 64'(mem_addr_o), 64'(x.addr));
                chk("dmem_we", 64'(mem_we_o), 64'(x.we));
                chk("dmem_wdata", 64'(mem_wdata_o), 64'(x.wdata));
                chk("dmem_rdata", 64'(dmem_rdata_o), 64'(x.rdata));
            end
            chk_order("D");
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((xi.size() + xd.size()) > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_pending", 64'(xi.size() + xd.size()), 64'd0);
        chk("order_left", 64'(ord.size()), 64'd0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        iq.delete();
        dq.delete();
        xi.delete();
        xd.delete();
        ord.delete();
        imem_valid_i = 1'b0;
        imem_addr_i  = '0;
        imem_wdata_i = '0;
        imem_we_i    = 4'd0;
        dmem_valid_i = 1'b0;
        dmem_addr_i  = '0;
        dmem_wdata_i = '0;
        dmem_we_i    = 4'd0;
        mem_ready_i  = 1'b0;
        scnt         = 0;
        i_fin        = 1'b0;
        d_fin        = 1'b0;
        use_ovr      = 1'b0;
        ovr          = '0;
        #1;
        chk("rst_mem_valid", 64'(mem_valid_o), 64'd0);
        chk("rst_dmem_ready", 64'(dmem_ready_o), 64'd0);
        chk("rst_outputs",
            64'(|{mem_addr_o, mem_wdata_o, mem_we_o, imem_rdata_o,
                  dmem_rdata_o, imem_ready_o}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_streak", 64'(dut.r_d_streak), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        checks   = 0;
        failures = 0;
        i_real   = 0;
        lat      = 0;
        do_reset();

        // single fetch, two-cycle slave
        lat     = 2;
        use_ovr = 1'b1;
        ovr     = 32'hDEAD_BEEF;
        push_i(32'h100);
        exp_order("I");
        tick();
        chk("t1_c0_valid", 64'(mem_valid_o), 64'd0);
        tick();
        chk("t1_c1_valid", 64'(mem_valid_o), 64'd1);
        chk("t1_c1_addr", 64'(mem_addr_o), 64'h100);
        chk("t1_c1_drdy", 64'(dmem_ready_o), 64'd0);
        tick();
        chk("t1_c2_irdy", 64'(imem_ready_o), 64'd0);
        chk("t1_c2_drdy", 64'(dmem_ready_o), 64'd0);
        tick();
        chk("t1_c3_irdy", 64'(imem_ready_o), 64'd1);
        chk("t1_c3_rdata", 64'(imem_rdata_o), 64'hDEAD_BEEF);
        chk("t1_c3_drdy", 64'(dmem_ready_o), 64'd0);
        wait_done(10);

        // simultaneous store and fetch
        do_reset();
        lat = 0;
        push_d(32'h8000, 4'hF, 32'h1234_5678);
        push_i(32'h200);
        exp_order("DI");
        wait_done(20);

        // starvation bound with both held high
        do_reset();
        lat = 0;
        for (int k = 0; k < 8; k++)
            push_d(32'h9000 + 32'(4 * k), 4'd0, '0);
        for (int k = 0; k < 2; k++)
            push_i(32'h300 + 32'(4 * k));
        exp_order("DDDDIDDDDI");
        wait_done(60);

        // back-to-back fetches
        do_reset();
        lat  = 0;
        base = i_real;
        push_i(32'h0);
        push_i(32'h4);
        push_i(32'h8);
        exp_order("III");
        tick();
        chk("t4_c0_valid", 64'(mem_valid_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_valid", 64'(mem_valid_o), 64'd1);
            chk("t4_irdy", 64'(imem_ready_o), 64'd1);
            chk("t4_addr", 64'(mem_addr_o), 64'(4 * k));
        end
        wait_done(10);
        chk("t4_pulses", 64'(i_real - base), 64'd3);

        // slave stall with fetch arriving mid-stall
        do_reset();
        lat = 5;
        push_d(32'hA000, 4'd0, '0);
        exp_order("DI");
        tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t5_valid", 64'(mem_valid_o), 64'd1);
            chk("t5_addr", 64'(mem_addr_o), 64'hA000);
            chk("t5_drdy", 64'(dmem_ready_o), 64'd0);
            chk("t5_irdy", 64'(imem_ready_o), 64'd0);
            if (k == 2)
                push_i(32'h400);
        end
        tick();
        chk("t5_done", 64'(dmem_ready_o), 64'd1);
        wait_done(40);

        // reset during a stalled dmem grant
        do_reset();
        lat = 20;
        push_d(32'hB000, 4'd0, '0);
        tick();
        tick();
        tick();
        chk("t6_pre_valid", 64'(mem_valid_o), 64'd1);
        chk("t6_pre_addr", 64'(mem_addr_o), 64'hB000);
        do_reset();
        lat = 0;
        chk("t6_streak", 64'(dut.r_d_streak), 64'd0);
        push_d(32'hC000, 4'd0, '0);
        push_i(32'hC100);
        exp_order("DI");
        tick();
        tick();
        chk("t6_first_valid", 64'(mem_valid_o), 64'd1);
        chk("t6_first_addr", 64'(mem_addr_o), 64'hC000);
        wait_done(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
